uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
Parametrised serial receiver, successor to the fixed 8N1 receiver. It oversamples `rxbit` and majority-votes each bit at mid-period. It rejects glitched start bits, supports configurable data width, parity and stop bits, and flags parity, framing and overrun errors. A held-valid/ack handshake lets the consumer (paddle/score control logic) take bytes at its own pace.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB received first.
OVERSAMPLE, 16, `bounderClock` cycles per bit period, even, >= 8.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.

Ports:
bounderClock  input  1  single clock, OVERSAMPLE x baud rate.
reset  input  1  asynchronous, active-low reset.
rxbit  input  1  asynchronous serial line, idle high.
ack  input  1  consumer has taken `dataout`; clears OUT_STATUS_READY.
dataout  output  DATA_BITS  last committed frame data.
OUT_STATUS_READY  output  1  high while `dataout` holds an unacknowledged frame.
parity_error  output  1  parity mismatch on the last committed frame (0 when PARITY_MODE = 0).
framing_error  output  1  a stop bit of the last committed frame sampled 0.
overrun_error  output  1  sticky; a frame completed while OUT_STATUS_READY = 1 without ack.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, `reset` = 0):
  - All outputs 0; state IDLE; counters 0.
  - Both synchronizer flops and the previous-sample flop set to 1, so reset release never causes a false start.
  - Reset asserted mid-frame discards the partial frame.
- Input path: `rxbit` passes through a 2-flop synchronizer. `rx_s` is the synchronized value; `rx_prev` is `rx_s` delayed one cycle.
- Timing:
  - Tick counter runs 0..OVERSAMPLE-1 within each bit period and wraps to 0, which advances to the next bit.
  - MID = OVERSAMPLE/2.
  - Samples are taken at counts MID-1, MID and MID+1. The bit value is the 2-of-3 majority, decided at count MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `rx_prev` = 1 and `rx_s` = 0 moves to START with the tick counter at 0.
  - START: a majority of 1 is a false start; return to IDLE at count MID+1 with no flags touched. Otherwise, at wrap, go to DATA with the bit index at 0.
  - DATA: the decided bit shifts into the shift register MSB-first-in, so the LSB lands first. After DATA_BITS periods go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: the decided bit is compared with the XOR of the data bits (inverted for odd parity). A mismatch sets an internal `perr`.
  - STOP: each stop bit decided 0 sets an internal `ferr`. At the decision point (count MID+1) of the last stop bit, COMMIT and go directly to IDLE. The remaining half stop bit is not waited for, so back-to-back frames are accepted.
- COMMIT cycle:
  - If OUT_STATUS_READY = 0, or `ack` = 1 in the same cycle:
    - `dataout` <= shift register.
    - `parity_error` <= `perr`; `framing_error` <= `ferr`.
    - OUT_STATUS_READY <= 1.
  - Otherwise the frame is dropped: `dataout` and the error flags are unchanged, and `overrun_error` <= 1.
  - Data is still delivered when `ferr` or `perr` is set.
- `ack` handling:
  - `ack` with no commit clears OUT_STATUS_READY and `overrun_error` on the next edge.
  - `ack` coinciding with a commit: the commit wins; OUT_STATUS_READY stays 1 and `overrun_error` is cleared.
  - `ack` while OUT_STATUS_READY = 0 is ignored.
- Break (line held low):
  - Commits a frame with `framing_error` = 1.
  - IDLE then waits for `rx_s` to return to 1 before the next start edge is accepted; this is inherent to the edge detect.
- Latency:
  - Commit occurs (N-1)·OVERSAMPLE + MID + 1 cycles after START entry, where N = 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS.
  - START entry is 3 cycles after the falling edge on `rxbit`.
  - Outputs are registered, so they are visible the cycle after commit.

Test Plan:
- Defaults; send 0xA5 as 8N1 at 16 cycles/bit -> OUT_STATUS_READY rises 153 cycles after START entry, `dataout` = 0xA5, all error flags 0; `ack` clears READY the next cycle.
- 1-cycle and 3-cycle low glitches on an idle line -> no READY, `busy` returns to 0 by count MID+1, no flags set.
- PARITY_MODE = 1; send 0x03 with parity bit 1 -> `dataout` = 0x03, `parity_error` = 1. Resend with parity bit 0 -> `parity_error` = 0.
- Send 0x55 with the stop bit forced 0 -> `dataout` = 0x55, `framing_error` = 1. Hold the line low for 30 bit periods, then release -> exactly one further frame (0x00, `framing_error` = 1). The next valid frame is then received clean.
- Two back-to-back frames 0x11, 0x22 with no `ack` -> `dataout` = 0x11, `overrun_error` = 1. Repeat with `ack` pulsed on the second commit cycle -> `dataout` = 0x22, no overrun.
- DATA_BITS = 9, STOP_BITS = 2, PARITY_MODE = 2; send 0x1FF; assert `reset` low during DATA of a second frame -> first frame is correct. After reset, all outputs are 0 and no false start occurs. A following frame 0x0AA is received correctly.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 2-of-3 vote around mid-bit, glitch-rejecting start detect,
// configurable data/parity/stop framing, held-valid/ack output with sticky overrun.
module uart_rx_oversampled #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 bounderClock,
  input  logic                 reset,
  input  logic                 rxbit,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 OUT_STATUS_READY,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam int unsigned MID   = OVERSAMPLE / 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rx_meta, rx_s, rx_prev, samp_a, samp_b;
  logic [2:0]           state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n, ferr, ferr_n;
  logic [DATA_BITS-1:0] dataout_n;
  logic                 ready_n, parity_error_n, framing_error_n, overrun_n, busy_n;
  logic                 maj, at_dec, at_wrap, commit, par_exp;

  // Line synchronizer and the two early vote samples; idle-high reset avoids a false start
  always_ff @(posedge bounderClock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
    end else begin
      rx_meta <= rxbit;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if (cnt == CNT_W'(MID - 1)) samp_a <= rx_s;
      if (cnt == CNT_W'(MID))     samp_b <= rx_s;
    end
  end

  assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign at_dec  = (cnt == CNT_W'(MID + 1));
  assign at_wrap = (cnt == CNT_W'(OVERSAMPLE - 1));
  assign par_exp = (^shreg) ^ (PARITY_MODE == 2);

  always_ff @(posedge bounderClock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      idx              <= '0;
      shreg            <= '0;
      perr             <= 1'b0;
      ferr             <= 1'b0;
      dataout          <= '0;
      OUT_STATUS_READY <= 1'b0;
      parity_error     <= 1'b0;
      framing_error    <= 1'b0;
      overrun_error    <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      idx              <= idx_n;
      shreg            <= shreg_n;
      perr             <= perr_n;
      ferr             <= ferr_n;
      dataout          <= dataout_n;
      OUT_STATUS_READY <= ready_n;
      parity_error     <= parity_error_n;
      framing_error    <= framing_error_n;
      overrun_error    <= overrun_n;
      busy             <= busy_n;
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = at_wrap ? '0 : cnt + CNT_W'(1);
    idx_n           = idx;
    shreg_n         = shreg;
    perr_n          = perr;
    ferr_n          = ferr;
    commit          = 1'b0;
    dataout_n       = dataout;
    ready_n         = OUT_STATUS_READY;
    parity_error_n  = parity_error;
    framing_error_n = framing_error;
    overrun_n       = overrun_error;

    case (state)
      S_IDLE: begin
        cnt_n  = '0;
        idx_n  = '0;
        perr_n = 1'b0;
        ferr_n = 1'b0;
        if (rx_prev && !rx_s) state_n = S_START;
      end
      S_START: begin
        if (at_dec && maj) state_n = S_IDLE;
        else if (at_wrap)  state_n = S_DATA;
      end
      S_DATA: begin
        if (at_dec) shreg_n = {maj, shreg[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (idx == IDX_W'(DATA_BITS - 1)) begin
            state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (at_dec && (maj != par_exp)) perr_n = 1'b1;
        if (at_wrap) state_n = S_STOP;
      end
      S_STOP: begin
        if (at_dec) begin
          if (!maj) ferr_n = 1'b1;
          // Commit at mid-bit of the last stop so a back-to-back start edge is not missed
          if (idx == IDX_W'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_n = S_IDLE;
          end
        end
        if (at_wrap) idx_n = idx + IDX_W'(1);
      end
      default: state_n = S_IDLE;
    endcase

    if (commit) begin
      if (!OUT_STATUS_READY || ack) begin
        dataout_n       = shreg;
        parity_error_n  = perr;
        framing_error_n = ferr_n;
        ready_n         = 1'b1;
        if (ack) overrun_n = 1'b0;
      end else begin
        overrun_n = 1'b1;
      end
    end else if (ack && OUT_STATUS_READY) begin
      ready_n   = 1'b0;
      overrun_n = 1'b0;
    end

    busy_n = (state_n != S_IDLE);
  end
endmodule
